dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
Host-side controller that drives the team's single-bank DRAM command interface (ACT/READ/WRITE/PRE, 64 rows x 32 columns x 8 bits). It accepts single-beat host read/write requests through a valid/ready handshake. It issues the required PRE/ACT/READ/WRITE sequence under an open-page policy with programmable timing gaps, and returns read data on a response port. One request is in flight at a time.

Parameters:
T_RCD, 2, cycles from ACT to the following READ/WRITE (legal range 1..15)
T_RP, 2, cycles from PRE to the following ACT (legal range 1..15)
IDLE_CLOSE, 16, consecutive idle cycles with a row open before an automatic PRE (0 = never close)
RD_TIMEOUT, 4, cycles after READ to wait for dram_valid before flagging an error

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request present
req_ready  out  1  controller can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  11  {row[5:0], col[4:0]}
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle read-response pulse
rsp_data  out  8  read data (0 on error)
rsp_err  out  1  read timed out; qualified by rsp_valid
dram_cmd  out  2  00=ACT 01=READ 10=WRITE 11=PRE
dram_row  out  6  row address
dram_col  out  5  column address
dram_wr_data  out  8  write data
dram_rd_data  in  8  DRAM read data
dram_valid  in  1  DRAM read-valid pulse
row_open  out  1  controller's view: a row is open
open_row  out  6  currently open row

Behaviour:
- Reset values: state IDLE, row_open=0, open_row=0, dram_cmd=PRE, dram_row=0, dram_col=0, dram_wr_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, idle counter=0. Reset mid-operation abandons the request; no response is produced.
- All dram_* outputs are registered. The DRAM interface has no NOP, so each non-issue cycle drives a filler command:
  - row_open=1: ACT with dram_row=open_row.
  - row_open=0: PRE.
  - In both cases dram_col=0 and dram_wr_data=0.
- req_ready=1 only when the state is IDLE. A request is accepted at an edge with req_valid&&req_ready; the address and data are captured at that edge.
- States: IDLE, PRE, TRP, ACT, TRCD, ACCESS, RD_WAIT, RD_CAP.
- IDLE, on accept:
  - hit (row_open and row==open_row) -> ACCESS
  - conflict (row_open, different row) -> PRE
  - closed (row_open=0) -> ACT
- PRE: drive PRE for 1 cycle and clear row_open. Then T_RP-1 TRP filler cycles, then ACT.
- ACT: drive ACT with the request row for 1 cycle, set row_open and open_row. Then T_RCD-1 TRCD filler cycles, then ACCESS.
- ACCESS: drive READ or WRITE with row/col/data for exactly 1 cycle. A write returns to IDLE, so req_ready=1 in the next cycle. A read goes to RD_WAIT.
- RD_WAIT: wait for dram_valid. The DRAM presents dram_rd_data one cycle after its dram_valid pulse.
  - dram_valid seen -> RD_CAP.
  - RD_TIMEOUT cycles elapse with no dram_valid -> pulse rsp_valid=1, rsp_err=1, rsp_data=0, then IDLE.
- RD_CAP: register dram_rd_data. rsp_valid pulses for 1 cycle in the following cycle with rsp_err=0; the state returns to IDLE at the same edge.
- Latency from acceptance edge, with T_RCD=T_RP=2:
  - write hit: WRITE issued +1.
  - write closed: ACT +1, WRITE +3.
  - write conflict: PRE +1, ACT +3, WRITE +5.
  - read: rsp_valid 3 cycles after READ.
- Idle close: the counter increments each IDLE cycle with row_open=1 and no accept. When it reaches IDLE_CLOSE, the controller issues one PRE, clears row_open and zeroes the counter.
  - The counter is zeroed on accept and when row_open=0.
  - If an accept coincides with the counter hit, the request wins: no auto-PRE, and the request is classified against the still-open row.
- Back-to-back requests to the open row issue no ACT/PRE.

Decomposition:
- Package dram_pkg: dram_cmd_e enum (ACT=2'b00, READ=2'b01, WRITE=2'b10, PRE=2'b11), ROW_W=6, COL_W=5, DATA_W=8, ctrl_state_e.
- One sub-module, dram_timer: a loadable down-counter with done flag, shared by TRP, TRCD, RD_WAIT timeout and idle-close counting (or instantiated twice).

Test Plan:
- Reset, write req_addr=0x0A3 (row 5, col 3) data 0x5A with the DRAM responder model attached -> ACT row5 at +1, WRITE row5/col3/0x5A at +3, req_ready=1 at +4, row_open=1, open_row=5.
- Read 0x0A3 immediately after -> READ at +1, rsp_valid at +4 with rsp_data=0x5A, rsp_err=0, no ACT/PRE issued.
- Read 0x120 (row 9) with row 5 open -> PRE +1, ACT row9 +3, READ +5, rsp_valid +8 with the previously written row-9 data; open_row=9.
- No requests for 16 cycles after an access -> exactly one PRE, row_open=0, filler becomes PRE; the next request goes through ACT.
- Responder forced never to assert dram_valid, read issued -> after 4 cycles rsp_valid=1, rsp_err=1, rsp_data=0; req_ready returns to 1.
- Assert rst_n=0 during TRCD of a write -> all outputs at reset values, no WRITE issued, no rsp_valid after release.

Source files
------------

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// dram_pkg : shared types and widths for the host-side DRAM controller
// Revision : 1.0
// ============================================================================
package dram_pkg;

    localparam int ROW_W  = 6;
    localparam int COL_W  = 5;
    localparam int DATA_W = 8;
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int TMR_W  = 4;

    typedef enum logic [1:0] {
        ACT   = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        PRE   = 2'b11
    } dram_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_TRP,
        ST_ACT,
        ST_TRCD,
        ST_ACCESS,
        ST_RD_WAIT,
        ST_RD_CAP
    } ctrl_state_e;

    // A phase of N cycles includes the cycle that loads the timer.
    function automatic logic [TMR_W-1:0] tmr_len(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_if.sv
`default_nettype none
// ============================================================================
// dram_if : host request/response bus plus DRAM command bus
// Revision : 1.0
// ============================================================================
interface dram_if;
    import dram_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_err;
    dram_cmd_e            dram_cmd;
    logic [ROW_W-1:0]     dram_row;
    logic [COL_W-1:0]     dram_col;
    logic [DATA_W-1:0]    dram_wr_data;
    logic [DATA_W-1:0]    dram_rd_data;
    logic                 dram_valid;
    logic                 row_open;
    logic [ROW_W-1:0]     open_row;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, dram_rd_data, dram_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, dram_cmd, dram_row,
               dram_col, dram_wr_data, row_open, open_row
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, dram_rd_data, dram_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err, dram_cmd, dram_row,
               dram_col, dram_wr_data, row_open, open_row
    );

endinterface
`default_nettype wire

// File: rtl/dram_timer.sv
`default_nettype none
// ============================================================================
// dram_timer : loadable down-counter, done while the count sits at zero
// Revision : 1.0
// ============================================================================
module dram_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    output logic                  done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
// dram_ctrl : open-page single-bank DRAM controller, one request in flight
// Revision : 1.0
// ============================================================================
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int T_RCD      = 2,
    parameter int T_RP       = 2,
    parameter int IDLE_CLOSE = 16,
    parameter int RD_TIMEOUT = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dram_if.slave     bus
);

    localparam int             ICW        = (IDLE_CLOSE < 2) ? 1 : $clog2(IDLE_CLOSE + 1);
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(IDLE_CLOSE);

    ctrl_state_e       state_q, state_d;
    logic              row_open_q, row_open_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic [ICW-1:0]    idle_cnt_q, idle_cnt_d;
    dram_cmd_e         cmd_q, cmd_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rq_write_q, rq_write_d;
    logic [ROW_W-1:0]  rq_row_q, rq_row_d;
    logic [COL_W-1:0]  rq_col_q, rq_col_d;
    logic [DATA_W-1:0] rq_wdata_q, rq_wdata_d;

    logic              accept;
    logic              go_pre, go_act, go_acc;
    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    dram_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        idle_cnt_d  = idle_cnt_q;
        rq_write_d  = rq_write_q;
        rq_row_d    = rq_row_q;
        rq_col_d    = rq_col_q;
        rq_wdata_d  = rq_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        go_pre      = 1'b0;
        go_act      = 1'b0;
        go_acc      = 1'b0;
        cmd_d       = PRE;
        row_d       = '0;
        col_d       = '0;
        wdata_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rq_write_d = bus.req_write;
                    rq_row_d   = bus.req_addr[ADDR_W-1:COL_W];
                    rq_col_d   = bus.req_addr[COL_W-1:0];
                    rq_wdata_d = bus.req_wdata;
                    idle_cnt_d = '0;
                    if (row_open_q && (rq_row_d == open_row_q)) begin
                        state_d = ST_ACCESS;
                        go_acc  = 1'b1;
                    end else if (row_open_q) begin
                        state_d = ST_PRE;
                        go_pre  = 1'b1;
                    end else begin
                        state_d = ST_ACT;
                        go_act  = 1'b1;
                    end
                end else if (row_open_q) begin
                    // Auto-close stays in IDLE; a same-edge accept above takes priority.
                    if ((IDLE_CLOSE != 0) && ((idle_cnt_q + ICW'(1)) == IDLE_LIMIT)) begin
                        go_pre     = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + ICW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_PRE, ST_TRP: begin
                if (tmr_done) begin
                    state_d = ST_ACT;
                    go_act  = 1'b1;
                end else begin
                    state_d = ST_TRP;
                end
            end
            ST_ACT, ST_TRCD: begin
                if (tmr_done) begin
                    state_d = ST_ACCESS;
                    go_acc  = 1'b1;
                end else begin
                    state_d = ST_TRCD;
                end
            end
            ST_ACCESS: begin
                if (rq_write_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_RD_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_len(RD_TIMEOUT);
                end
            end
            ST_RD_WAIT: begin
                if (bus.dram_valid) begin
                    state_d = ST_RD_CAP;
                end else if (tmr_done) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            ST_RD_CAP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.dram_rd_data;
            end
            default: state_d = ST_IDLE;
        endcase

        // Command registers are loaded with what the next cycle must drive.
        if (go_pre) begin
            cmd_d      = PRE;
            row_open_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = tmr_len(T_RP);
        end else if (go_act) begin
            cmd_d      = ACT;
            row_d      = rq_row_d;
            row_open_d = 1'b1;
            open_row_d = rq_row_d;
            tmr_load   = 1'b1;
            tmr_val    = tmr_len(T_RCD);
        end else if (go_acc) begin
            cmd_d   = rq_write_d ? WRITE : READ;
            row_d   = rq_row_d;
            col_d   = rq_col_d;
            wdata_d = rq_write_d ? rq_wdata_d : '0;
        end else if (row_open_d) begin
            cmd_d = ACT;
            row_d = open_row_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_open_q  <= 1'b0;
            open_row_q  <= '0;
            idle_cnt_q  <= '0;
            cmd_q       <= PRE;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rq_write_q  <= 1'b0;
            rq_row_q    <= '0;
            rq_col_q    <= '0;
            rq_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            idle_cnt_q  <= idle_cnt_d;
            cmd_q       <= cmd_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rq_write_q  <= rq_write_d;
            rq_row_q    <= rq_row_d;
            rq_col_q    <= rq_col_d;
            rq_wdata_q  <= rq_wdata_d;
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.dram_cmd     = cmd_q;
    assign bus.dram_row     = row_q;
    assign bus.dram_col     = col_q;
    assign bus.dram_wr_data = wdata_q;
    assign bus.row_open     = row_open_q;
    assign bus.open_row     = open_row_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dram_ctrl : directed + random requests against a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_dram_ctrl;
    import dram_pkg::*;

    localparam int T_RCD      = 2;
    localparam int T_RP       = 2;
    localparam int IDLE_CLOSE = 16;
    localparam int RD_TIMEOUT = 4;

    logic clk;
    logic rst_n;
    dram_if u_if ();

    dram_ctrl #(
        .T_RCD      (T_RCD),
        .T_RP       (T_RP),
        .IDLE_CLOSE (IDLE_CLOSE),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        m_open;
    logic [5:0]  m_row;
    int          m_cnt;
    logic        rsp_now;
    bit          no_rsp;
    logic [7:0]  ref_mem [2048];
    logic [7:0]  rsp_mem [2048];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] vec(input logic [1:0] c, input logic [5:0] r, input logic [4:0] cl,
                                        input logic [7:0] d, input logic o, input logic [5:0] orw);
        return {4'b0, c, r, cl, d, o, orw};
    endfunction

    function automatic logic [31:0] obs_vec();
        return vec(u_if.dram_cmd, u_if.dram_row, u_if.dram_col, u_if.dram_wr_data,
                   u_if.row_open, u_if.open_row);
    endfunction

    function automatic logic [31:0] filler_vec();
        return m_open ? vec(ACT, m_row, 5'd0, 8'd0, 1'b1, m_row) : vec(PRE, 6'd0, 5'd0, 8'd0, 1'b0, m_row);
    endfunction

    // DRAM responder: dram_valid the cycle after a READ, data one cycle later.
    initial begin : responder
        logic        p1, p2;
        logic [10:0] a1, a2;
        p1 = 1'b0; p2 = 1'b0; a1 = '0; a2 = '0;
        u_if.dram_valid   = 1'b0;
        u_if.dram_rd_data = '0;
        forever begin
            @(negedge clk);
            u_if.dram_valid = 1'b0;
            if (p2) begin
                u_if.dram_rd_data = rsp_mem[a2];
                p2 = 1'b0;
            end
            if (p1) begin
                u_if.dram_valid = 1'b1;
                p2 = 1'b1; a2 = a1; p1 = 1'b0;
            end
            if (rst_n && u_if.dram_cmd == READ && !no_rsp) begin
                p1 = 1'b1; a1 = {u_if.dram_row, u_if.dram_col};
            end
            if (rst_n && u_if.dram_cmd == WRITE)
                rsp_mem[{u_if.dram_row, u_if.dram_col}] = u_if.dram_wr_data;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_val("idle_cmd", obs_vec(), filler_vec());
            check_val("idle_ready", 32'(u_if.req_ready), 32'd1);
            check_val("idle_rsp", 32'(u_if.rsp_valid), 32'(rsp_now));
            rsp_now = 1'b0;
            if (m_open) begin
                m_cnt++;
                if (m_cnt == IDLE_CLOSE) begin
                    m_open = 1'b0;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_req(input logic w, input logic [10:0] addr, input logic [7:0] wd);
        int         t_pre, t_act, t_acc, t_rsp;
        logic [5:0] row;
        logic [4:0] col;
        row = addr[10:5]; col = addr[4:0];
        t_pre = 0; t_act = 0;
        if (m_open && m_row == row) begin
            t_acc = 1;
        end else if (m_open) begin
            t_pre = 1; t_act = 1 + T_RP; t_acc = t_act + T_RCD;
        end else begin
            t_act = 1; t_acc = 1 + T_RCD;
        end
        check_val("acc_ready", 32'(u_if.req_ready), 32'd1);
        check_val("acc_cmd", obs_vec(), filler_vec());
        check_val("acc_rsp", 32'(u_if.rsp_valid), 32'(rsp_now));
        rsp_now = 1'b0;
        u_if.req_valid = 1'b1; u_if.req_write = w; u_if.req_addr = addr; u_if.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        u_if.req_valid = 1'b0;
        u_if.req_write = 1'($urandom);
        u_if.req_addr  = 11'($urandom);
        u_if.req_wdata = 8'($urandom);
        m_cnt = 0;
        for (int k = 1; k <= t_acc; k++) begin
            logic [31:0] e;
            if (k == t_pre) begin
                m_open = 1'b0;
                e = vec(PRE, 6'd0, 5'd0, 8'd0, 1'b0, m_row);
            end else if (k == t_act) begin
                m_open = 1'b1; m_row = row;
                e = vec(ACT, row, 5'd0, 8'd0, 1'b1, row);
            end else if (k == t_acc) begin
                e = vec(w ? WRITE : READ, row, col, w ? wd : 8'd0, 1'b1, row);
            end else begin
                e = filler_vec();
            end
            check_val("cmd", obs_vec(), e);
            check_val("busy", 32'(u_if.req_ready), 32'd0);
            check_val("busy_rsp", 32'(u_if.rsp_valid), 32'd0);
            @(negedge clk);
        end
        if (w) begin
            ref_mem[addr] = wd;
            return;
        end
        t_rsp = no_rsp ? RD_TIMEOUT + 1 : 3;
        for (int j = 1; j < t_rsp; j++) begin
            check_val("rd_wait_cmd", obs_vec(), filler_vec());
            check_val("rd_wait_ready", 32'(u_if.req_ready), 32'd0);
            check_val("rd_wait_rsp", 32'(u_if.rsp_valid), 32'd0);
            @(negedge clk);
        end
        check_val("rsp_valid", 32'(u_if.rsp_valid), 32'd1);
        check_val("rsp_err", 32'(u_if.rsp_err), 32'(no_rsp));
        check_val("rsp_data", 32'(u_if.rsp_data), no_rsp ? 32'd0 : 32'(ref_mem[addr]));
        check_val("rsp_ready", 32'(u_if.req_ready), 32'd1);
        rsp_now = 1'b1;
    endtask

    // Request through a different row, then reset during its TRCD window.
    task automatic reset_in_trcd();
        logic [5:0] row;
        int         t_acc;
        row   = m_open ? m_row + 6'd1 : 6'd17;
        t_acc = m_open ? 1 + T_RP + T_RCD : 1 + T_RCD;
        u_if.req_valid = 1'b1; u_if.req_write = 1'b1;
        u_if.req_addr  = {row, 5'd7}; u_if.req_wdata = 8'hE7;
        @(posedge clk);
        @(negedge clk);
        u_if.req_valid = 1'b0;
        for (int k = 1; k < t_acc - 1; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_cmd", obs_vec(), vec(PRE, 6'd0, 5'd0, 8'd0, 1'b0, 6'd0));
        check_val("rst_rsp", {u_if.rsp_valid, u_if.rsp_err, u_if.rsp_data}, 32'd0);
        check_val("rst_ready", 32'(u_if.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_open = 1'b0; m_row = '0; m_cnt = 0; rsp_now = 1'b0;
        idle(6);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic       w;
        logic [5:0] row;
        int         gap;
        rst_n = 1'b0;
        u_if.req_valid = 1'b0; u_if.req_write = 1'b0;
        u_if.req_addr  = '0;   u_if.req_wdata = '0;
        no_rsp = 1'b0;
        m_open = 1'b0; m_row = '0; m_cnt = 0; rsp_now = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = 8'($urandom);
            rsp_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        check_val("reset_cmd", obs_vec(), vec(PRE, 6'd0, 5'd0, 8'd0, 1'b0, 6'd0));
        check_val("reset_rsp", {u_if.rsp_valid, u_if.rsp_err, u_if.rsp_data}, 32'd0);
        check_val("reset_ready", 32'(u_if.req_ready), 32'd1);
        rst_n = 1'b1;

        do_req(1'b1, 11'h0A3, 8'h5A);
        check_val("open_row5", {u_if.row_open, u_if.open_row}, {25'd0, 1'b1, 6'd5});
        do_req(1'b0, 11'h0A3, 8'h00);
        do_req(1'b1, 11'h120, 8'hC3);
        do_req(1'b1, 11'h0A4, 8'h11);
        do_req(1'b0, 11'h120, 8'h00);
        check_val("open_row9", {u_if.row_open, u_if.open_row}, {25'd0, 1'b1, 6'd9});
        idle(IDLE_CLOSE + 2);
        check_val("auto_close", 32'(u_if.row_open), 32'd0);
        do_req(1'b1, 11'h0A3, 8'h77);
        idle(IDLE_CLOSE - 1);
        do_req(1'b0, 11'h0A3, 8'h00);
        no_rsp = 1'b1;
        do_req(1'b0, 11'h0A5, 8'h00);
        no_rsp = 1'b0;
        do_req(1'b0, 11'h0A3, 8'h00);
        reset_in_trcd();

        for (int n = 0; n < 80; n++) begin
            gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 2));
            idle(gap);
            w      = 1'($urandom);
            row    = 6'($urandom_range(0, 3));
            no_rsp = ($urandom_range(0, 9) == 0);
            do_req(w, {row, 5'($urandom)}, 8'($urandom));
        end
        no_rsp = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
